// File: rtl/cpu19_pkg.sv
// Shared widths, opcode encoding and the execute-stage operand bundle
// for the 19-bit CPU.
package cpu19_pkg;

    localparam int XLEN = 19;
    localparam int NREG = 8;
    localparam int AW   = $clog2(NREG);
    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_SUB  = 5'd2,
        OP_AND  = 5'd3,
        OP_OR   = 5'd4,
        OP_XOR  = 5'd5,
        OP_SLL  = 5'd6,
        OP_SRL  = 5'd7,
        OP_ADDI = 5'd8,
        OP_LD   = 5'd9,
        OP_ST   = 5'd10,
        OP_BEQ  = 5'd11,
        OP_JAL  = 5'd12
    } opcode_e;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [AW-1:0]   rd;
        logic            rd_we;
    } ex_bundle_t;

    // x0 is never written, so a writeback to it never counts as a hit.
    function automatic logic wb_hits(input logic          wb_valid,
                                     input logic [AW-1:0] wb_addr,
                                     input logic [AW-1:0] r);
        return wb_valid && (wb_addr == r) && (r != '0);
    endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register pending-write tracker; reports RAW/WAW hazards that the
// current writeback does not already resolve.
module operand_scoreboard
    import cpu19_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush_i,
    input  logic          set_en_i,
    input  logic [AW-1:0] set_addr_i,
    input  logic          clr_en_i,
    input  logic [AW-1:0] clr_addr_i,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_we_i,
    output logic          hazard_rs1_o,
    output logic          hazard_rs2_o,
    output logic          hazard_rd_o
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;

    // A new writer issuing in the same cycle as an older writeback wins.
    always_comb begin
        pending_next = pending;
        for (int r = 1; r < NREG; r++) begin
            if (set_en_i && (set_addr_i == AW'(r))) begin
                pending_next[r] = 1'b1;
            end else if (wb_hits(clr_en_i, clr_addr_i, AW'(r))) begin
                pending_next[r] = 1'b0;
            end
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else if (flush_i) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign hazard_rs1_o = pending[rs1_addr_i] & ~wb_hits(clr_en_i, clr_addr_i, rs1_addr_i);
    assign hazard_rs2_o = pending[rs2_addr_i] & ~wb_hits(clr_en_i, clr_addr_i, rs2_addr_i);
    assign hazard_rd_o  = rd_we_i & pending[rd_addr_i] & ~wb_hits(clr_en_i, clr_addr_i, rd_addr_i);

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: reads operands with writeback bypass, stalls on pending
// registers and registers the operand bundle toward execute.
module operand_fetch
    import cpu19_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [OP_W-1:0] in_op_i,
    input  logic [AW-1:0]   in_rs1_addr_i,
    input  logic [AW-1:0]   in_rs2_addr_i,
    input  logic [AW-1:0]   in_rd_addr_i,
    input  logic            in_rd_we_i,
    input  logic [XLEN-1:0] in_imm_i,
    output logic [AW-1:0]   rf_rs1_addr_o,
    output logic [AW-1:0]   rf_rs2_addr_o,
    input  logic [XLEN-1:0] rf_rs1_data_i,
    input  logic [XLEN-1:0] rf_rs2_data_i,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_rd_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [OP_W-1:0] ex_op_o,
    output logic [XLEN-1:0] ex_rs1_data_o,
    output logic [XLEN-1:0] ex_rs2_data_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [AW-1:0]   ex_rd_addr_o,
    output logic            ex_rd_we_o
);

    logic       hazard_rs1;
    logic       hazard_rs2;
    logic       hazard_rd;
    logic       hazard;
    logic       slot_free;
    logic       fire;
    logic       ex_valid_q;
    ex_bundle_t ex_q;
    ex_bundle_t ex_next;

    assign rf_rs1_addr_o = in_rs1_addr_i;
    assign rf_rs2_addr_o = in_rs2_addr_i;

    operand_scoreboard u_scoreboard (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (flush_i),
        .set_en_i     (fire & in_rd_we_i),
        .set_addr_i   (in_rd_addr_i),
        .clr_en_i     (wb_valid_i),
        .clr_addr_i   (wb_rd_addr_i),
        .rs1_addr_i   (in_rs1_addr_i),
        .rs2_addr_i   (in_rs2_addr_i),
        .rd_addr_i    (in_rd_addr_i),
        .rd_we_i      (in_rd_we_i),
        .hazard_rs1_o (hazard_rs1),
        .hazard_rs2_o (hazard_rs2),
        .hazard_rd_o  (hazard_rd)
    );

    assign hazard     = hazard_rs1 | hazard_rs2 | hazard_rd;
    assign slot_free  = ~ex_valid_q | ex_ready_i;
    assign in_ready_o = slot_free & ~hazard & ~flush_i;
    assign fire       = in_valid_i & in_ready_o;

    // The regfile returns the pre-write value, so a same-cycle writeback
    // must be forwarded here.
    always_comb begin
        ex_next.op    = in_op_i;
        ex_next.imm   = in_imm_i;
        ex_next.rd    = in_rd_addr_i;
        ex_next.rd_we = in_rd_we_i;
        ex_next.rs1   = rf_rs1_data_i;
        ex_next.rs2   = rf_rs2_data_i;
        if (in_rs1_addr_i == '0) begin
            ex_next.rs1 = '0;
        end else if (wb_hits(wb_valid_i, wb_rd_addr_i, in_rs1_addr_i)) begin
            ex_next.rs1 = wb_data_i;
        end
        if (in_rs2_addr_i == '0) begin
            ex_next.rs2 = '0;
        end else if (wb_hits(wb_valid_i, wb_rd_addr_i, in_rs2_addr_i)) begin
            ex_next.rs2 = wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (flush_i) begin
            ex_valid_q <= 1'b0;
        end else if (slot_free) begin
            ex_valid_q <= fire;
            if (fire) begin
                ex_q <= ex_next;
            end
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_op_o       = ex_q.op;
    assign ex_rs1_data_o = ex_q.rs1;
    assign ex_rs2_data_o = ex_q.rs2;
    assign ex_imm_o      = ex_q.imm;
    assign ex_rd_addr_o  = ex_q.rd;
    assign ex_rd_we_o    = ex_q.rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed issue vectors push hand-computed
// bundles; a negedge monitor pops and compares each bundle execute accepts.
module tb_operand_fetch;
    import cpu19_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_op;
    logic [AW-1:0]   in_rs1_addr;
    logic [AW-1:0]   in_rs2_addr;
    logic [AW-1:0]   in_rd_addr;
    logic            in_rd_we;
    logic [XLEN-1:0] in_imm;
    logic [AW-1:0]   rf_rs1_addr;
    logic [AW-1:0]   rf_rs2_addr;
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [OP_W-1:0] ex_op;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [AW-1:0]   ex_rd_addr;
    logic            ex_rd_we;

    logic [XLEN-1:0] regs [NREG];
    ex_bundle_t      exp_q [$];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_op_i       (in_op),
        .in_rs1_addr_i (in_rs1_addr),
        .in_rs2_addr_i (in_rs2_addr),
        .in_rd_addr_i  (in_rd_addr),
        .in_rd_we_i    (in_rd_we),
        .in_imm_i      (in_imm),
        .rf_rs1_addr_o (rf_rs1_addr),
        .rf_rs2_addr_o (rf_rs2_addr),
        .rf_rs1_data_i (rf_rs1_data),
        .rf_rs2_data_i (rf_rs2_data),
        .wb_valid_i    (wb_valid),
        .wb_rd_addr_i  (wb_rd_addr),
        .wb_data_i     (wb_data),
        .flush_i       (flush),
        .ex_valid_o    (ex_valid),
        .ex_ready_i    (ex_ready),
        .ex_op_o       (ex_op),
        .ex_rs1_data_o (ex_rs1_data),
        .ex_rs2_data_o (ex_rs2_data),
        .ex_imm_o      (ex_imm),
        .ex_rd_addr_o  (ex_rd_addr),
        .ex_rd_we_o    (ex_rd_we)
    );

    // Regfile model: combinational read of the pre-write value.
    always @(posedge clk) begin
        if (wb_valid && wb_rd_addr != '0) regs[wb_rd_addr] <= wb_data;
    end
    assign rf_rs1_data = regs[rf_rs1_addr];
    assign rf_rs2_data = regs[rf_rs2_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected bundle: got op 0x%0h expected none", ex_op);
            end else begin
                ex_bundle_t e;
                e = exp_q.pop_front();
                checkOutput("ex_op",    32'(ex_op),       32'(e.op));
                checkOutput("ex_rs1",   32'(ex_rs1_data), 32'(e.rs1));
                checkOutput("ex_rs2",   32'(ex_rs2_data), 32'(e.rs2));
                checkOutput("ex_imm",   32'(ex_imm),      32'(e.imm));
                checkOutput("ex_rd",    32'(ex_rd_addr),  32'(e.rd));
                checkOutput("ex_rd_we", 32'(ex_rd_we),    32'(e.rd_we));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the instruction fires.
    task automatic applyStimulus(input int op, input int rs1, input int rs2, input int rd,
                                 input int we, input int imm, input int exp_rs1,
                                 input int exp_rs2, input int exp_stalls, input string name);
        int         stalls;
        ex_bundle_t e;
        stalls      = 0;
        in_valid    = 1'b1;
        in_op       = OP_W'(op);
        in_rs1_addr = AW'(rs1);
        in_rs2_addr = AW'(rs2);
        in_rd_addr  = AW'(rd);
        in_rd_we    = we[0];
        in_imm      = XLEN'(imm);
        @(negedge clk);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got in_ready 0 expected 1", name);
        end else begin
            e.op    = OP_W'(op);
            e.rs1   = XLEN'(exp_rs1);
            e.rs2   = XLEN'(exp_rs2);
            e.imm   = XLEN'(imm);
            e.rd    = AW'(rd);
            e.rd_we = we[0];
            exp_q.push_back(e);
            checkOutput({name, " stalls"}, 32'(stalls), 32'(exp_stalls));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic driveWb(input int delay, input int addr, input int data);
        repeat (delay) @(posedge clk);
        if (delay > 0) #1;
        wb_valid   = 1'b1;
        wb_rd_addr = AW'(addr);
        wb_data    = XLEN'(data);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " ex_valid"}, 32'(ex_valid),    32'd0);
        checkOutput({tag, " ex_op"},    32'(ex_op),       32'd0);
        checkOutput({tag, " ex_rs1"},   32'(ex_rs1_data), 32'd0);
        checkOutput({tag, " ex_rs2"},   32'(ex_rs2_data), 32'd0);
        checkOutput({tag, " ex_imm"},   32'(ex_imm),      32'd0);
        checkOutput({tag, " ex_rd"},    32'(ex_rd_addr),  32'd0);
        checkOutput({tag, " ex_rd_we"}, 32'(ex_rd_we),    32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1_addr = '0; in_rs2_addr = '0;
        in_rd_addr = '0; in_rd_we = 1'b0; in_imm = '0; wb_valid = 1'b0; wb_rd_addr = '0;
        wb_data = '0; flush = 1'b0; ex_ready = 1'b1;

        // Preload the regfile through writeback while the stage is in reset.
        @(posedge clk); #1;
        for (int r = 1; r < NREG; r++) begin
            wb_valid   = 1'b1;
            wb_rd_addr = AW'(r);
            wb_data    = (r == 3) ? 19'h12345 : XLEN'(r * 32'h111);
            @(posedge clk); #1;
        end
        wb_valid = 1'b0;
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("ready after reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        applyStimulus(1, 3, 0, 1, 0, 'h00ABC, 'h12345, 0, 0, "x3 read");
        applyStimulus(2, 1, 2, 0, 0, 'h7FFFF, 'h00111, 'h00222, 0, "two regs");

        // RAW stall resolved by a bypassed writeback.
        applyStimulus(3, 1, 2, 5, 1, 'h00005, 'h00111, 'h00222, 0, "write x5");
        fork
            applyStimulus(4, 5, 0, 6, 0, 'h00001, 'h7ABCD, 0, 3, "raw x5");
            driveWb(3, 5, 'h7ABCD);
        join

        // Issue and writeback of the same rd in one cycle: the new writer stays pending.
        fork
            applyStimulus(5, 2, 3, 2, 1, 'h00003, 'h05A5A, 'h12345, 0, "set+clr x2");
            driveWb(0, 2, 'h05A5A);
        join
        fork
            applyStimulus(6, 2, 0, 7, 0, 'h00002, 'h01234, 0, 2, "raw x2");
            driveWb(2, 2, 'h01234);
        join

        // Execute backpressure.
        @(posedge clk); #1;
        ex_ready = 1'b0;
        fork
            begin
                applyStimulus(7, 4, 5, 3, 0, 'h00001, 'h00444, 'h7ABCD, 0, "bp first");
                applyStimulus(8, 7, 6, 0, 0, 'h00010, 'h00777, 'h00666, 3, "bp second");
            end
            begin
                @(posedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput("bp valid", 32'(ex_valid),    32'd1);
                    checkOutput("bp rs1",   32'(ex_rs1_data), 32'h00444);
                    checkOutput("bp rs2",   32'(ex_rs2_data), 32'h7ABCD);
                    checkOutput("bp ready", 32'(in_ready),    32'd0);
                end
                @(posedge clk); #1;
                ex_ready = 1'b1;
            end
        join

        // x0 destinations and sources, then flush of a held bundle.
        applyStimulus(9,  1, 0, 0, 1, 'h00020, 'h00111, 0, 0, "rd x0");
        applyStimulus(10, 0, 0, 3, 0, 'h00030, 0, 0, 0, "rs x0");
        applyStimulus(11, 0, 0, 4, 1, 'h00044, 0, 0, 0, "write x4");
        in_rd_we = 1'b0;
        in_rd_addr = '0;
        ex_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        ex_ready = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        checkOutput("flush valid", 32'(ex_valid), 32'd0);
        @(posedge clk); #1;
        applyStimulus(12, 4, 0, 1, 0, 'h00040, 'h00444, 0, 0, "after flush");

        // Reset while a follower is stalled.
        applyStimulus(13, 1, 2, 6, 1, 'h00060, 'h00111, 'h01234, 0, "write x6");
        in_valid = 1'b1; in_op = 5'd14; in_rs1_addr = 3'd6; in_rs2_addr = '0;
        in_rd_addr = '0; in_rd_we = 1'b0; in_imm = 19'h00070;
        @(negedge clk);
        checkOutput("raw x6 ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkResetState("mid reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("ready after mid reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        applyStimulus(14, 6, 0, 0, 0, 'h00070, 'h00666, 0, 0, "re-present");

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("queue drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
